coax_tx: RTL and testbench
==========================

Name: coax_tx

Overview:
- Transmit serializer that consumes the half-bit phase and bit-end strobe of an internal coax_bit_timer instance and drives the Manchester-encoded coax line.
- Accepts 10-bit words through a one-word holding buffer.
- Frames each burst as line quiesce, code violation, one or more words (sync + 10 data + parity), then the end sequence.
- Sits between the host/register interface and the line driver; drives the line-driver enable.

Parameters:
- CLOCKS_PER_BIT, 8, clocks per bit cell; passed to coax_bit_timer; must be even and >= 4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- data  input  10  word to transmit, bit 9 first
- strobe  input  1  write request; captures data when ready=1
- ready  output  1  holding buffer empty; combinational ~buffer_full
- active  output  1  line driver enable, registered
- tx  output  1  line data, registered

Behaviour:
- Reset (async) forces: state IDLE, buffer empty, ready=1, active=0, tx=0, and bit timer reset. This applies mid-frame too; the frame is abandoned with no end sequence.
- Bit timer reset is held asserted while in IDLE, so every frame starts at counter 0.
- Cell encoding on halves (first, second):
  - bit 1 = (1, 0); bit 0 = (0, 1)
  - CV_A = (0, 0); CV_B = (0, 1); CV_C = (1, 1)
  - END_H = (1, 1)
- tx = cell value selected by timer first_half/second_half, registered. tx lags the internal timer by exactly 1 clock, and every cell is exactly CLOCKS_PER_BIT clocks wide on tx.
- States and advance rules:
  - IDLE: strobe with buffer empty loads the buffer, then goes to QUIESCE.
  - QUIESCE: 5 bit-1 cells.
  - CV: CV_A, CV_B, CV_C.
  - SYNC: one bit-1 cell; at entry the buffer moves to the shift register and the buffer empties.
  - DATA: 10 cells, bits 9 down to 0.
  - PARITY: one cell, value = XOR of the 10 data bits (even parity over data+parity).
  - After PARITY: if the buffer is full, go to SYNC; otherwise go to END.
  - END: one bit-0 cell, then END_H, then IDLE.
  - All advances occur on end_strobe.
- Handshake:
  - strobe while ready=0 is ignored; data is not captured and there is no error flag.
  - At most one word is buffered in addition to the word being shifted.
  - A word accepted anywhere before the end_strobe of PARITY is chained without a gap.
  - A word accepted during END or later starts a new frame after IDLE.
- active: 1 from the cycle after frame-start acceptance through the final END_H clock; drops to 0 in the same cycle tx returns to 0.
- Latency: strobe accepted in IDLE at cycle n gives tx/active valid from n+1.
- Frame length for N chained words = 5 + 3 + 12N + 2 bit cells. For N=1 at the default this is 176 clocks.
- No gaps or extra cells between chained words.
- Simultaneous events: strobe on the cycle the buffer empties (SYNC entry) is ignored because ready was 0 that cycle. ready rises the next cycle.

Test Plan:
- Reset idle: hold reset, then release with no strobe → tx=0, active=0, ready=1 for 500 clocks.
- Single word 10'h2A5: strobe once → active high exactly 176 clocks. Check decoded cells: 5×1, CV low 12 / high 12 clocks, sync 1, data 1010100101, parity 1, 0, END_H; ready=0 until SYNC entry.
- Parity: words 10'h000 and 10'h3FF → parity cell 0 both; 10'h001 → parity 1.
- Chaining: second strobe (10'h155) during first word's DATA → active for 272 clocks; second SYNC follows first PARITY with no gap. A third strobe while ready=0 is ignored, with no third word on the line.
- Late strobe: strobe during END cell → first frame completes (active low ≥1 clock), then a new full frame with quiesce and CV.
- Async reset mid-DATA (bit 4) → tx=0, active=0, ready=1 immediately without a clock edge. Next strobe yields a clean 176-clock frame.

Source files
------------

// File: rtl/coax_tx.sv
// Manchester coax transmit serializer: quiesce + code violation + chained words
// (sync, 10 data bits MSB first, even parity) + end sequence, paced by coax_bit_timer.

module coax_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic first_half,
  output logic second_half,
  output logic end_strobe
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign first_half  = cnt_q < CW'(CLOCKS_PER_BIT / 2);
  assign second_half = ~first_half;
  assign end_strobe  = cnt_q == CW'(CLOCKS_PER_BIT - 1);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || end_strobe) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

module coax_tx #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       strobe,
  output logic       ready,
  output logic       active,
  output logic       tx
);
  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_CV, S_SYNC, S_DATA, S_PARITY, S_END
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cell_q, cell_d;
  logic [9:0] buf_q, buf_d, shift_q, shift_d;
  logic       buf_full_q, buf_full_d;
  logic       par_q, par_d;
  logic       active_q, active_d, tx_q, tx_d;

  logic accept, start, timer_clr, frame_on;
  logic first_half, second_half, end_strobe;
  logic cell_f, cell_s;

  coax_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
    .clk(clk), .reset(reset), .clear(timer_clr),
    .first_half(first_half), .second_half(second_half), .end_strobe(end_strobe)
  );

  assign ready  = ~buf_full_q;
  assign active = active_q;
  assign tx     = tx_q;

  // A buffered word waiting in IDLE starts only once active has been low a cycle.
  assign accept    = strobe & ~buf_full_q;
  assign start     = (state_q == S_IDLE) & (accept | buf_full_q) & ~active_q;
  assign timer_clr = (state_q == S_IDLE) & ~start;
  assign frame_on  = (state_q != S_IDLE) | start;

  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cell_f     = 1'b1;
    cell_s     = 1'b0;

    if (accept) begin
      buf_d      = data;
      buf_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_QUIESCE;
        cell_d  = '0;
      end
      S_QUIESCE: if (end_strobe) begin
        cell_d = cell_q + 4'd1;
        if (cell_q == 4'd4) begin
          state_d = S_CV;
          cell_d  = '0;
        end
      end
      S_CV: begin
        cell_f = (cell_q == 4'd2);
        cell_s = (cell_q != 4'd0);
        if (end_strobe) begin
          cell_d = cell_q + 4'd1;
          if (cell_q == 4'd2) state_d = S_SYNC;
        end
      end
      S_SYNC: if (end_strobe) begin
        state_d = S_DATA;
        cell_d  = '0;
      end
      S_DATA: begin
        cell_f = shift_q[9];
        cell_s = ~shift_q[9];
        if (end_strobe) begin
          shift_d = {shift_q[8:0], 1'b0};
          cell_d  = cell_q + 4'd1;
          if (cell_q == 4'd9) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        cell_f = par_q;
        cell_s = ~par_q;
        if (end_strobe) begin
          state_d = buf_full_q ? S_SYNC : S_END;
          cell_d  = '0;
        end
      end
      S_END: begin
        cell_f = (cell_q != 4'd0);
        cell_s = 1'b1;
        if (end_strobe) begin
          cell_d = cell_q + 4'd1;
          if (cell_q == 4'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering SYNC hands the buffered word to the shifter.
    if (state_d == S_SYNC && state_q != S_SYNC) begin
      shift_d    = buf_q;
      par_d      = ^buf_q;
      buf_full_d = 1'b0;
    end

    active_d = frame_on;
    tx_d     = frame_on & ((first_half & cell_f) | (second_half & cell_s));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cell_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      active_q   <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      active_q   <= active_d;
      tx_q       <= tx_d;
    end
  end
endmodule

// File: tb/tb_coax_tx.sv
// Bench for coax_tx: captures each active burst of tx and compares it clock by
// clock against a frame built directly from the word list.

module tb_coax_tx;
  localparam int CPB = 8;
  localparam int H   = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] data = '0;
  logic       strobe = 1'b0;
  logic       ready, active, tx;

  int checks = 0;
  int errors = 0;

  coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(rst), .data(data), .strobe(strobe),
    .ready(ready), .active(active), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  // Burst monitor: one entry per contiguous active run, with the idle gap before it.
  int           frame_len[$];
  logic [511:0] frame_bits[$];
  int           frame_gap[$];
  logic         in_frame = 1'b0;
  int           cur_len  = 0;
  logic [511:0] cur_bits = '0;
  int           gap      = 1000;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      cur_len  = 0;
      gap      = 1000;
    end else if (active) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        cur_len  = 0;
        cur_bits = '0;
        frame_gap.push_back(gap);
      end
      if (cur_len < 512) cur_bits[cur_len] = tx;
      cur_len++;
    end else begin
      if (in_frame) begin
        frame_len.push_back(cur_len);
        frame_bits.push_back(cur_bits);
        in_frame = 1'b0;
        gap = 0;
      end
      gap++;
    end
  end

  // Reference frame: list of (first, second) half values per cell, expanded to clocks.
  function automatic void build(input logic [9:0] w[$], output int len,
                                output logic [511:0] bits);
    logic f[$];
    logic s[$];
    repeat (5) begin f.push_back(1'b1); s.push_back(1'b0); end
    f.push_back(1'b0); s.push_back(1'b0);
    f.push_back(1'b0); s.push_back(1'b1);
    f.push_back(1'b1); s.push_back(1'b1);
    foreach (w[k]) begin
      logic [9:0] word;
      int ones;
      word = w[k];
      ones = 0;
      f.push_back(1'b1); s.push_back(1'b0);
      for (int b = 9; b >= 0; b--) begin
        f.push_back(word[b]); s.push_back(!word[b]);
        if (word[b]) ones++;
      end
      f.push_back(ones % 2 == 1); s.push_back(ones % 2 == 0);
    end
    f.push_back(1'b0); s.push_back(1'b1);
    f.push_back(1'b1); s.push_back(1'b1);
    bits = '0;
    len  = 0;
    foreach (f[c]) begin
      for (int i = 0; i < H; i++) begin bits[len] = f[c]; len++; end
      for (int i = 0; i < H; i++) begin bits[len] = s[c]; len++; end
    end
  endfunction

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frame_len.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (frame_len.size() < n) chk("timeout", frame_len.size(), n);
  endtask

  task automatic cmp_frame(input string tag, input logic [9:0] w[$],
                           output logic [511:0] got, output int gap_before);
    int elen, alen, n;
    logic [511:0] ebits;
    got = '0;
    gap_before = 0;
    if (frame_len.size() == 0) begin
      chk({tag, "_missing"}, 0, 1);
      return;
    end
    alen       = frame_len.pop_front();
    got        = frame_bits.pop_front();
    gap_before = frame_gap.pop_front();
    build(w, elen, ebits);
    chk({tag, "_len"}, alen, elen);
    n = (alen < elen) ? alen : elen;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_tx%0d", tag, i), int'(got[i]), int'(ebits[i]));
  endtask

  task automatic send(input logic [9:0] w);
    @(negedge clk);
    data   = w;
    strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic single(input string tag, input logic [9:0] w, input int exp_par);
    logic [9:0]   wq[$];
    logic [511:0] got;
    int           g;
    wq = '{w};
    send(w);
    wait_frames(1, 400);
    cmp_frame(tag, wq, got, g);
    // Parity cell is cell 19; sample its first half.
    if (exp_par >= 0) chk({tag, "_parity"}, int'(got[19*CPB]), exp_par);
  endtask

  initial begin
    logic [9:0]   wq[$];
    logic [511:0] got;
    int           g, bad;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 0);
    chk("rst_active", active, 0);
    chk("rst_ready", ready, 1);
    @(negedge clk) rst = 1'b0;

    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b0 || active !== 1'b0 || ready !== 1'b1) bad++;
    end
    chk("idle_500", bad, 0);

    // Single word with latency and ready timing.
    @(negedge clk);
    data = 10'h2A5; strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
    chk("lat_active", active, 1);
    chk("lat_tx", tx, 1);
    chk("busy_ready", ready, 0);
    repeat (62) @(posedge clk);
    #1 chk("ready_before_sync", ready, 0);
    @(posedge clk);
    #1 chk("ready_at_sync", ready, 1);
    wq = '{10'h2A5};
    wait_frames(1, 400);
    cmp_frame("w2a5", wq, got, g);
    chk("w2a5_parity", int'(got[19*CPB]), 1);

    single("p000", 10'h000, 0);
    single("p3ff", 10'h3FF, 0);
    single("p001", 10'h001, 1);
    repeat (6) single("rnd", 10'($urandom), -1);

    // Chain: second word during DATA, third while ready is low.
    send(10'h2A5);
    repeat (90) @(posedge clk);
    send(10'h155);
    send(10'h0F0);
    wq = '{10'h2A5, 10'h155};
    wait_frames(1, 600);
    cmp_frame("chain", wq, got, g);
    repeat (300) @(posedge clk);
    chk("no_third", frame_len.size(), 0);

    // Random chain offset inside the window after SYNC entry and before PARITY ends.
    begin
      logic [9:0] a, b;
      a = 10'($urandom);
      b = 10'($urandom);
      send(a);
      repeat ($urandom_range(70, 150)) @(posedge clk);
      send(b);
      wq = '{a, b};
      wait_frames(1, 600);
      cmp_frame("rchain", wq, got, g);
    end

    // Late strobe during END: two separate frames with a gap.
    send(10'h2A5);
    repeat (160) @(posedge clk);
    send(10'h0C3);
    wait_frames(2, 800);
    wq = '{10'h2A5};
    cmp_frame("late1", wq, got, g);
    wq = '{10'h0C3};
    cmp_frame("late2", wq, got, g);
    chk("late_gap_ok", int'(g >= 1), 1);

    // Async reset in the middle of data bit 4.
    send(10'h2A5);
    repeat (105) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", tx, 0);
    chk("arst_active", active, 0);
    chk("arst_ready", ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    frame_len.delete(); frame_bits.delete(); frame_gap.delete();
    single("post_rst", 10'h2A5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
